// File: rtl/serial_adder_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the bit-serial adder: FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_adder_pkg;

    // 2'd3 is never entered; the FSM default arm steers it back to IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
`timescale 1ns/1ps
// Single-bit full adder cell used as the serial adder datapath.
// Latency: purely combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
`timescale 1ns/1ps
// Bit-serial WIDTH-bit adder: one operand bit pair per clock through one full_adder, LSB first.
// Latency: done pulses WIDTH cycles after the start edge; one result per WIDTH+2 cycles.
// Backpressure: none; start is ignored unless idle, results held until the next completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 low result bits collected so far; the MSB comes straight from the cell
    logic [WIDTH-2:0] s_sh;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] s_next;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c_reg),
        .s    (fa_s),
        .cout (fa_co)
    );

    // New result bit enters at the top so after WIDTH shifts the word is LSB-aligned
    assign s_next = {fa_s, s_sh};

    // FSM, operand/result shifters, carry register, bit counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            c_reg     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= operand_a;
                        b_sh  <= operand_b;
                        c_reg <= carry_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next[WIDTH-1:1];
                    c_reg <= fa_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // On the MSB edge c_reg is the carry into the MSB, fa_co the carry out of it
                        sum       <= s_next;
                        carry_out <= fa_co;
                        overflow  <= c_reg ^ fa_co;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
